// File: rtl/aes_pkg.sv
// Shared AES decrypt-side types, inverse S-box and GF(2^8) helpers.
// State byte k lives at bits [127-8k -: 8]; row r = bytes 4r..4r+3.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_byte_t inv_sbox(input aes_byte_t b);
        return INV_SBOX[b];
    endfunction

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // col = {a0, a1, a2, a3}, a0 in the top byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        aes_byte_t a [4];
        aes_byte_t b [4];
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            b[i] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[2'(i + 1)], 8'h0b)
                 ^ gf_mul(a[2'(i + 2)], 8'h0d) ^ gf_mul(a[2'(i + 3)], 8'h09);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t  r;
        logic [31:0] mixed;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            mixed = inv_mix_column({s[127-8*c -: 8], s[127-8*(4+c) -: 8],
                                    s[127-8*(8+c) -: 8], s[127-8*(12+c) -: 8]});
            r[127-8*c -: 8]      = mixed[31:24];
            r[127-8*(4+c) -: 8]  = mixed[23:16];
            r[127-8*(8+c) -: 8]  = mixed[15:8];
            r[127-8*(12+c) -: 8] = mixed[7:0];
        end
        return r;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return r;
    endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r (bytes 4r..4r+3) rotated right by r byte positions.
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic [127:0] in_state,
    output logic [127:0] out_state
);

    always_comb begin
        out_state = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                out_state[127-8*(4*r+c) -: 8] = in_state[127-8*(4*r+((c+4-r)%4)) -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_inv_round.sv
// One AES inverse round per beat with valid/ready on both sides.
// AES_INV_ROUND_PIPE_EN adds a register after InvSubBytes (latency 2 instead of 1).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    aes_state_t shifted;
    aes_state_t subbed;
    logic       out_valid_q, out_valid_d;
    aes_state_t out_state_q, out_state_d;
    logic       out_advance;

    inv_shift_rows u_inv_shift_rows (
        .in_state  (in_state),
        .out_state (shifted)
    );

    always_comb begin
        subbed      = inv_sub_bytes(shifted);
        out_advance = !out_valid_q || out_ready;
    end

`ifdef AES_INV_ROUND_PIPE_EN
    logic       s0_valid_q, s0_valid_d;
    aes_state_t s0_data_q, s0_data_d;
    aes_state_t s0_key_q, s0_key_d;
    logic       s0_mix_q, s0_mix_d;
    aes_state_t s1_keyed;
    aes_state_t s1_result;

    always_comb begin
        in_ready   = !s0_valid_q || out_advance;
        s0_valid_d = s0_valid_q;
        s0_data_d  = s0_data_q;
        s0_key_d   = s0_key_q;
        s0_mix_d   = s0_mix_q;
        if (in_ready) begin
            s0_valid_d = in_valid;
            if (in_valid) begin
                // Key-add-only beats bypass the shift/substitute path.
                s0_data_d = in_first ? in_state : subbed;
                s0_key_d  = in_key;
                s0_mix_d  = !in_first && !in_last;
            end
        end

        s1_keyed    = s0_data_q ^ s0_key_q;
        s1_result   = s0_mix_q ? inv_mix_columns(s1_keyed) : s1_keyed;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        if (out_advance) begin
            out_valid_d = s0_valid_q;
            if (s0_valid_q) out_state_d = s1_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_key_q   <= '0;
            s0_mix_q   <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_data_q  <= s0_data_d;
            s0_key_q   <= s0_key_d;
            s0_mix_q   <= s0_mix_d;
        end
    end
`else
    aes_state_t keyed;
    aes_state_t result;

    always_comb begin
        in_ready    = out_advance;
        keyed       = (in_first ? in_state : subbed) ^ in_key;
        result      = (!in_first && !in_last) ? inv_mix_columns(keyed) : keyed;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        if (out_advance) begin
            out_valid_d = in_valid;
            if (in_valid) out_state_d = result;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_aes_inv_round.sv
// Self-checking bench for aes_inv_round: known-answer table, backpressure, reset and
// randomized traffic against a byte-array model whose S-box is derived from GF(2^8) inversion.
module tb_aes_inv_round;

`ifdef AES_INV_ROUND_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [127:0] fwd_in;
    logic [127:0] isr_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] exp_q [$];
    logic         hold_prev = 1'b0;
    logic [127:0] hold_state;

    aes_inv_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    inv_shift_rows u_isr (
        .in_state  (fwd_in),
        .out_state (isr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Carry-less product reduced by long division with 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic void build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic f, input logic l);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   o [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = st[127-8*i -: 8];
            k[i] = key[127-8*i -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[4*r+c] = isbox[s[4*r+((c+4-r)%4)]] ^ k[4*r+c];
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                o[4*i+c] = ref_mul(8'h0e, t[4*i+c]) ^ ref_mul(8'h0b, t[4*((i+1)%4)+c])
                         ^ ref_mul(8'h0d, t[4*((i+2)%4)+c]) ^ ref_mul(8'h09, t[4*((i+3)%4)+c]);
        for (int i = 0; i < 16; i++) begin
            if (f)      res[127-8*i -: 8] = s[i] ^ k[i];
            else if (l) res[127-8*i -: 8] = t[i];
            else        res[127-8*i -: 8] = o[i];
        end
        return res;
    endfunction

    function automatic logic [127:0] fwd_shift(input logic [127:0] st);
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127-8*(4*r+c) -: 8] = st[127-8*(4*r+((c+r)%4)) -: 8];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard and output-hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 128'(out_valid), 128'd1);
                chk("hold_state", out_state, hold_state);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", out_state, 128'hx);
                else                   chk("scoreboard", out_state, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_round(in_state, in_key, in_first, in_last));
            hold_prev  = out_valid && !out_ready;
            hold_state = out_state;
        end
    end

    typedef struct {
        string        nm;
        logic [127:0] st;
        logic [127:0] key;
        logic         f;
        logic         l;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        in_valid  = 1'b1;
        in_state  = v.st;
        in_key    = v.key;
        in_first  = v.f;
        in_last   = v.l;
        out_ready = 1'b1;
        @(negedge clk);
        chk({v.nm, "_in_ready"}, 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        chk({v.nm, "_latency"}, 128'(lat), 128'(LAT));
        chk({v.nm, "_out"}, out_state, v.exp);
        step();
        chk({v.nm, "_drained"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] beats [4];
        logic [127:0] stall_state;
        logic         acc;
        int           idx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        fwd_in    = '0;
        build_tables();

        vecs[0] = '{"key_add", 128'h0, {128{1'b1}}, 1'b1, 1'b0, {128{1'b1}}};
        vecs[1] = '{"last_round", {16{8'h63}}, 128'h0, 1'b0, 1'b1, 128'h0};
        vecs[2] = '{"row_check", 128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'h0, 1'b0, 1'b1,
                    128'h00010203_07040506_0a0b0809_0d0e0f0c};
        vecs[3] = '{"inv_mix", {16{8'h63}}, 128'h8e000000_4d000000_a1000000_bc000000, 1'b0, 1'b0,
                    128'hdb000000_13000000_53000000_45000000};
        vecs[4] = '{"first_over_last", 128'h00112233_44556677_8899aabb_ccddeeff, {16{8'h0f}},
                    1'b1, 1'b1, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0};

        // Forward and inverse row shifts must compose to identity.
        for (int i = 0; i < 4; i++) begin
            x      = rand128();
            fwd_in = fwd_shift(x);
            #1;
            chk("shift_identity", isr_out, x);
        end

        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_state", out_state, 128'h0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: out_ready low for cycles 2..4 of a 4-beat stream.
        for (int i = 0; i < 4; i++) beats[i] = rand128();
        idx         = 0;
        stall_state = '0;
        for (int cyc = 0; cyc < 40 && (idx < 4 || exp_q.size() > 0); cyc++) begin
            in_valid  = idx < 4;
            in_state  = beats[idx % 4];
            in_key    = ~beats[idx % 4];
            in_first  = 1'b0;
            in_last   = idx[0];
            out_ready = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 2) stall_state = out_state;
            if (cyc == 3 || cyc == 4) begin
                chk("bp_in_ready_low", 128'(in_ready), 128'd0);
                chk("bp_out_valid", 128'(out_valid), 128'd1);
                chk("bp_out_stable", out_state, stall_state);
            end
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 128'(idx), 128'd4);
        chk("bp_all_emitted", 128'(exp_q.size()), 128'd0);

        // Reset while a result is pending and a new beat is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = rand128();
        in_key    = rand128();
        idx       = 0;
        while (!out_valid && idx < 8) begin
            step();
            idx++;
        end
        chk("rst_setup_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
        chk("rst_mid_out_state", out_state, 128'h0);
        chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_ghost", 128'(out_valid), 128'd0);
        end

        // Randomized traffic; a beat is held until accepted.
        acc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 9) < 7;
                in_state = rand128();
                in_key   = rand128();
                in_first = $urandom_range(0, 3) == 0;
                in_last  = $urandom_range(0, 2) == 0;
            end
            out_ready = $urandom_range(0, 9) < 7;
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) step();
        chk("random_drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
